// File: rtl/cfuop_requant_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cfuop_requant_if                                                       |
// | CFU command/response handshake bundle for the requantization unit.    |
// | Rev 1.0  initial release                                               |
// +------------------------------------------------------------------------+
interface cfuop_requant_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface
`default_nettype wire

// File: rtl/cfuop_requant.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cfuop_requant                                                          |
// | int32 accumulator -> quantized output (bias, TFLite multiplier/shift, |
// | output offset, activation clamp). Optional macro                      |
// | CFUOP_REQUANT_PACK_EN turns sub-op 3 into a byte-packing requant.     |
// | Rev 1.0  initial release                                               |
// +------------------------------------------------------------------------+
module cfuop_requant #(
  parameter int PIPE_STAGES = 3
) (
  input  logic           clk,
  input  logic           reset,
  cfuop_requant_if.slave bus
);
  // Last compute state code tracks the stage count; RESP follows it.
  localparam logic [2:0] ST_LAST = 3'(PIPE_STAGES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = ST_LAST,
    RESP = ST_LAST + 3'd1
  } state_e;

  localparam logic [1:0] OP_SET_MULT = 2'd0;
  localparam logic [1:0] OP_SET_OUT  = 2'd1;
  localparam logic [1:0] OP_REQUANT  = 2'd2;

  state_e state_q, state_d;
  logic [1:0]  subop;
  logic        accept, compute_op;
  logic        cmd_ready, rsp_valid;

  logic signed [31:0] mult_q, off_q, min_q, max_q;
  logic        [7:0]  shift_q;
  logic signed [31:0] a_q, b_q, x_q, y_q;
  logic        [31:0] rsp_q;

  assign subop  = bus.cmd_payload_function_id[4:3];
  assign accept = bus.cmd_valid && (state_q == IDLE);

`ifdef CFUOP_REQUANT_PACK_EN
  assign compute_op = subop[1];
`else
  assign compute_op = (subop == OP_REQUANT);
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = compute_op ? S1 : RESP;
      end
      S1:   state_d = S2;
      S2:   state_d = S3;
      S3:   state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: bias add and left shift
  logic [31:0] sum, x_d;
  logic [7:0]  neg_shift;
  logic [4:0]  left, right;
  assign sum       = a_q + b_q;
  assign neg_shift = 8'd0 - shift_q;
  assign left      = shift_q[7] ? 5'd0 : shift_q[4:0];
  assign right     = shift_q[7] ? neg_shift[4:0] : 5'd0;
  assign x_d       = sum << left;

  // Stage 2: saturating rounding doubling high multiply
  logic signed [63:0] ab, ab_nudged, ab_adj, quo;
  logic signed [31:0] y_d;
  assign ab        = $signed({{32{x_q[31]}}, x_q}) * $signed({{32{mult_q[31]}}, mult_q});
  assign ab_nudged = ab + (ab[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000);
  // Bias negatives so the arithmetic shift truncates toward zero.
  assign ab_adj    = ab_nudged + (ab_nudged[63] ? 64'sh0000_0000_7FFF_FFFF : 64'sh0);
  assign quo       = ab_adj >>> 31;
  assign y_d       = (x_q == 32'sh8000_0000 && mult_q == 32'sh8000_0000)
                     ? 32'sh7FFF_FFFF : quo[31:0];

  // Stage 3: rounding divide by power of two, offset, clamp
  logic [31:0]        mask, rem, thr, shifted, rounded;
  logic signed [31:0] biased, lo_clamped, clamped;
  assign mask       = (32'd1 << right) - 32'd1;
  assign rem        = y_q & mask;
  assign thr        = (mask >> 1) + {31'd0, y_q[31]};
  assign shifted    = y_q >>> right;
  assign rounded    = shifted + {31'd0, (rem > thr)};
  assign biased     = rounded + off_q;
  assign lo_clamped = (biased < min_q) ? min_q : biased;
  assign clamped    = (lo_clamped > max_q) ? max_q : lo_clamped;

`ifdef CFUOP_REQUANT_PACK_EN
  logic [31:0] pack_q, pack_d;
  logic [1:0]  pack_cnt_q;
  logic        pack_op_q;
  always_comb begin
    pack_d = pack_q;
    pack_d[{pack_cnt_q, 3'b000} +: 8] = clamped[7:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mult_q  <= '0;
      shift_q <= '0;
      off_q   <= '0;
      min_q   <= -32'sd128;
      max_q   <= 32'sd127;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rsp_q   <= '0;
`ifdef CFUOP_REQUANT_PACK_EN
      pack_q     <= '0;
      pack_cnt_q <= '0;
      pack_op_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        case (subop)
          OP_SET_MULT: begin
            mult_q  <= bus.cmd_payload_inputs_0;
            shift_q <= bus.cmd_payload_inputs_1[7:0];
            rsp_q   <= '0;
          end
          OP_SET_OUT: begin
            off_q <= bus.cmd_payload_inputs_0;
            min_q <= {{16{bus.cmd_payload_inputs_1[15]}}, bus.cmd_payload_inputs_1[15:0]};
            max_q <= {{16{bus.cmd_payload_inputs_1[31]}}, bus.cmd_payload_inputs_1[31:16]};
            rsp_q <= '0;
          end
          OP_REQUANT: begin
            a_q <= bus.cmd_payload_inputs_0;
            b_q <= bus.cmd_payload_inputs_1;
`ifdef CFUOP_REQUANT_PACK_EN
            pack_op_q <= 1'b0;
`endif
          end
          default: begin
`ifdef CFUOP_REQUANT_PACK_EN
            a_q       <= bus.cmd_payload_inputs_0;
            b_q       <= bus.cmd_payload_inputs_1;
            pack_op_q <= 1'b1;
            if (pack_cnt_q == 2'd0) pack_q <= '0;
`else
            rsp_q <= '0;
`endif
          end
        endcase
      end
      if (state_q == S1) x_q <= x_d;
      if (state_q == S2) y_q <= y_d;
      if (state_q == S3) begin
`ifdef CFUOP_REQUANT_PACK_EN
        if (pack_op_q) begin
          pack_q     <= pack_d;
          pack_cnt_q <= pack_cnt_q + 2'd1;
          rsp_q      <= pack_d;
        end else begin
          rsp_q <= clamped;
        end
`else
        rsp_q <= clamped;
`endif
      end
    end
  end

  assign bus.cmd_ready             = cmd_ready;
  assign bus.rsp_valid             = rsp_valid;
  assign bus.rsp_payload_outputs_0 = rsp_q;

  logic unused_bits;
  assign unused_bits = ^{bus.cmd_payload_function_id[9:5], bus.cmd_payload_function_id[2:0],
                         shift_q[6:5], neg_shift[7:5], quo[63:32]};
endmodule
`default_nettype wire

// File: tb/tb_cfuop_requant.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cfuop_requant                                                       |
// | Randomized self-checking bench with an arithmetic reference model.    |
// | Rev 1.0  initial release                                               |
// +------------------------------------------------------------------------+
module tb_cfuop_requant;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cfuop_requant_if bus();
  cfuop_requant #(.PIPE_STAGES(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  localparam int TMO = 40;
  int errors = 0;
  int checks = 0;
  int m_mult, m_shift, m_off, m_min, m_max;

  // Reference: real-number semantics of the quantization rules.
  function automatic int ref_requant(input int acc, input int bias);
    int x, y, r, right;
    longint ab, nudge, p, q, rem;
    bit up;
    x = acc + bias;
    if (m_shift > 0) x = x << m_shift;
    if (x == 32'h8000_0000 && m_mult == 32'h8000_0000) y = 32'h7FFF_FFFF;
    else begin
      ab    = longint'(x) * longint'(m_mult);
      nudge = (ab >= 0) ? (longint'(1) << 30) : (longint'(1) - (longint'(1) << 30));
      y     = int'((ab + nudge) / (longint'(1) << 31));
    end
    right = (m_shift < 0) ? -m_shift : 0;
    p   = longint'(1) << right;
    q   = longint'(y) >>> right;
    rem = longint'(y) - q * p;
    up  = (y >= 0) ? (2 * rem >= p) : (2 * rem > p);
    r = int'(q) + int'(up);
    r = r + m_off;
    if (r < m_min) r = m_min;
    if (r > m_max) r = m_max;
    return r;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    int n;
    bus.cmd_payload_function_id = {5'd0, op, 3'd3};
    bus.cmd_payload_inputs_0 = a;
    bus.cmd_payload_inputs_1 = b;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < TMO) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < TMO) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_op();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    start_op(op, a, b, lat);
    res = bus.rsp_payload_outputs_0;
    finish_op();
  endtask

  task automatic set_mult(input int m, input int s);
    logic [31:0] r; int l;
    m_mult = m; m_shift = s;
    run_op(2'd0, m, s, r, l);
  endtask

  task automatic set_out(input int off, input int mn, input int mx);
    logic [31:0] r; int l;
    m_off = off;
    m_min = {{16{mn[15]}}, mn[15:0]};
    m_max = {{16{mx[15]}}, mx[15:0]};
    run_op(2'd1, off, {mx[15:0], mn[15:0]}, r, l);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_payload_outputs_0 !== 32'd0) begin errors++; $display("FAIL reset_output: got %h expected 0", bus.rsp_payload_outputs_0); end
    reset = 1'b0;
    m_mult = 0; m_shift = 0; m_off = 0; m_min = -128; m_max = 127;
  endtask

  task automatic test_default_requant();
    logic [31:0] r; int l;
    run_op(2'd2, 32'd1000, 32'd0, r, l);
    checks++; if (l !== 4) begin errors++; $display("FAIL requant_latency: got %0d expected 4", l); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL default_requant: got %h expected 0", r); end
  endtask

  task automatic test_example();
    logic [31:0] r; int l;
    m_mult = 32'h4000_0000; m_shift = -1;
    run_op(2'd0, 32'h4000_0000, -32'sd1, r, l);
    checks++; if (l !== 1) begin errors++; $display("FAIL config_latency: got %0d expected 1", l); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL config_output: got %h expected 0", r); end
    set_out(-200, -128, 127);
    run_op(2'd2, 32'd1000, 32'd24, r, l);
    checks++; if (r !== 32'd56) begin errors++; $display("FAIL example_56: got %h expected %h", r, 32'd56); end
  endtask

  task automatic test_neg_round();
    logic [31:0] r; int l;
    set_mult(32'h4000_0000, -1);
    set_out(0, -128, 127);
    run_op(2'd2, -32'sd3, 32'd0, r, l);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL neg_round: got %h expected ffffffff", r); end
  endtask

  task automatic test_saturation();
    logic [31:0] r; int l;
    set_mult(32'h8000_0000, 0);
    set_out(0, -32768, 32767);
    run_op(2'd2, 32'h8000_0000, 32'd0, r, l);
    checks++; if (r !== 32'd32767) begin errors++; $display("FAIL sat_16bit: got %h expected %h", r, 32'd32767); end
    set_out(0, -128, 127);
    run_op(2'd2, 32'h8000_0000, 32'd0, r, l);
    checks++; if (r !== 32'd127) begin errors++; $display("FAIL sat_8bit: got %h expected %h", r, 32'd127); end
    set_mult(32'h4000_0000, 0);
    set_out(0, 100, 50);
    run_op(2'd2, 32'd3000, 32'd0, r, l);
    checks++; if (r !== 32'd50) begin errors++; $display("FAIL inverted_clamp: got %h expected %h", r, 32'd50); end
  endtask

  task automatic test_random();
    logic [31:0] r; int l, acc, bias, exp_v;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) begin
        set_mult(($urandom_range(1) != 0) ? int'($urandom_range(32'h7FFF_FFFF, 32'h2000_0000)) : int'($urandom),
                 ($urandom_range(1) != 0) ? int'($urandom_range(12)) - 8 : int'($urandom_range(62)) - 31);
        if ($urandom_range(3) == 0) set_out(int'($urandom_range(200)) - 100, -32768, 32767);
        else set_out(int'($urandom_range(200)) - 100, int'($urandom_range(400)) - 300,
                     int'($urandom_range(400)) - 100);
      end
      acc  = ($urandom_range(1) != 0) ? int'($urandom_range(20000)) - 10000 : int'($urandom);
      bias = int'($urandom_range(2000)) - 1000;
      exp_v = ref_requant(acc, bias);
      run_op(2'd2, acc, bias, r, l);
      checks++; if (r !== exp_v) begin errors++; $display("FAIL random_requant[%0d]: got %h expected %h", i, r, exp_v); end
      checks++; if (l !== 4) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected 4", i, l); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_v; int l;
    set_mult(32'h4000_0000, -1);
    set_out(-200, -128, 127);
    exp_v = ref_requant(1000, 24);
    start_op(2'd2, 32'd1000, 32'd24, l);
    checks++; if (l !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", l); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_payload_outputs_0} !== {1'b1, 1'b0, exp_v}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b r=%b d=%h expected v=1 r=0 d=%h",
                 c, bus.rsp_valid, bus.cmd_ready, bus.rsp_payload_outputs_0, exp_v);
      end
    end
    finish_op();
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int l, acc, exp_v;
    set_mult(32'h5555_5555, -3);
    set_out(7, -1000, 1000);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      acc = int'($urandom_range(8000)) - 4000;
      exp_v = ref_requant(acc, 0);
      start_op(2'd2, acc, 32'd0, l);
      checks++; if (bus.rsp_payload_outputs_0 !== exp_v || l !== 4) begin
        errors++; $display("FAIL b2b[%0d]: got %h lat %0d expected %h lat 4", i, bus.rsp_payload_outputs_0, l, exp_v);
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [31:0] r; int l; bit seen;
    set_mult(32'h4000_0000, -1);
    set_out(5, -128, 127);
    bus.cmd_payload_function_id = {5'd0, 2'd2, 3'd3};
    bus.cmd_payload_inputs_0 = 32'd1000;
    bus.cmd_payload_inputs_1 = 32'd0;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_mult = 0; m_shift = 0; m_off = 0; m_min = -128; m_max = 127;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen |= bus.rsp_valid;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_rsp: got rsp_valid=1 expected 0"); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", bus.cmd_ready); end
    run_op(2'd2, 32'd5, 32'd0, r, l);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL post_reset_requant: got %h expected 0", r); end
  endtask

`ifdef CFUOP_REQUANT_PACK_EN
  task automatic test_pack();
    logic [31:0] r, m_pack; int l, cnt, v;
    set_mult(32'h7FFF_FFFF, 0);
    set_out(0, -128, 127);
    m_pack = 32'd0; cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      if (cnt == 0) m_pack = 32'd0;
      v = ref_requant(i, 0);
      m_pack[cnt*8 +: 8] = v[7:0];
      cnt = (cnt + 1) % 4;
      run_op(2'd3, i, 32'd0, r, l);
      checks++; if (r !== m_pack || l !== 4) begin
        errors++; $display("FAIL pack[%0d]: got %h lat %0d expected %h lat 4", i, r, l, m_pack);
      end
      if (i == 4) begin
        checks++; if (r !== 32'h0403_0201) begin errors++; $display("FAIL pack_full: got %h expected 04030201", r); end
      end
    end
    run_op(2'd2, 32'd9, 32'd0, r, l);
    checks++; if (r !== ref_requant(9, 0)) begin errors++; $display("FAIL pack_plain: got %h expected %h", r, ref_requant(9, 0)); end
  endtask
`else
  task automatic test_subop3();
    logic [31:0] r; int l, exp_v;
    set_mult(32'h6000_0000, -2);
    set_out(3, -128, 127);
    run_op(2'd3, $urandom, $urandom, r, l);
    checks++; if (r !== 32'd0 || l !== 1) begin errors++; $display("FAIL subop3: got %h lat %0d expected 0 lat 1", r, l); end
    exp_v = ref_requant(777, -7);
    run_op(2'd2, 32'd777, -32'sd7, r, l);
    checks++; if (r !== exp_v) begin errors++; $display("FAIL subop3_nochange: got %h expected %h", r, exp_v); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0 = '0;
    bus.cmd_payload_inputs_1 = '0;
    test_reset();
    test_default_requant();
    test_example();
    test_neg_round();
    test_saturation();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
`ifdef CFUOP_REQUANT_PACK_EN
    test_pack();
`else
    test_subop3();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cfuop_requant.md
Name: cfuop_requant

Overview:
- CFU functional unit on dispatcher slot funct3 = 3; dispatcher `NUM_CFUOP` becomes 4 and it routes this unit's handshake exactly as it routes the other units.
- Consumes int32 accumulators produced by the systolic-array unit.
- Applies bias, the TFLite fixed-point multiplier/shift, output offset and activation clamp, and returns the quantized value to the CPU.
- Holds its own quantization config registers, loaded by config sub-ops.

Parameters:
- PIPE_STAGES, 3, internal compute stages between accept and response; the latency rules below assume 3.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- cmd_valid  input  1  command valid, already gated by the dispatcher for funct3 == 3
- cmd_ready  output  1  unit can accept a command
- cmd_payload_function_id  input  10  [9:3] funct7, sub-op in [1:0]; [2:0] funct3
- cmd_payload_inputs_0  input  32  operand A
- cmd_payload_inputs_1  input  32  operand B
- rsp_valid  output  1  response valid
- rsp_ready  input  1  CPU accepts response (shared by all units)
- rsp_payload_outputs_0  output  32  result

Behaviour:
- Clocking: one clock, clk. Reset is synchronous, active-high, on port reset.
- State machine: IDLE, S1, S2, S3, RESP.
- Reset values:
  - state IDLE; cmd_ready=1; rsp_valid=0; rsp_payload_outputs_0=0.
  - mult=0, shift=0, out_offset=0, act_min=-128, act_max=127.
- Handshake:
  - cmd_ready=1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
  - In RESP, rsp_valid=1 and the output is held stable until rsp_ready=1, then the unit returns to IDLE. cmd_ready=1 in the following cycle.
  - rsp_ready while not in RESP is ignored.
- Sub-ops (funct7[1:0]):
  - 0 SET_MULT: mult=inputs_0; shift=inputs_1[7:0] (signed, legal range -31..+31). IDLE->RESP, output 0.
  - 1 SET_OUT: out_offset=inputs_0; act_min=sext(inputs_1[15:0]); act_max=sext(inputs_1[31:16]). IDLE->RESP, output 0.
  - 2 REQUANT: inputs_0=acc, inputs_1=bias. IDLE->S1->S2->S3->RESP, so rsp_valid is asserted 4 cycles after accept.
  - 3: without the optional feature, behaves as a config op returning 0 with no state change.
- REQUANT arithmetic (all int32 with wrap unless stated); operands are registered at accept:
  - S1: x = acc + bias (wrap); left = max(shift,0); right = max(-shift,0); x = x << left (truncated to 32 bits).
  - S2: SRDHM(x, mult).
    - If x == mult == 0x80000000, result = 0x7FFFFFFF.
    - Otherwise ab = 64-bit signed product; nudge = 2^30 if ab >= 0, else 1-2^30; result = (ab+nudge)/2^31, division truncating toward zero.
  - S3: RDBPOT(y, right): mask = 2^right-1; rem = y & mask; thr = (mask>>1) + (y<0); r = (y >>> right) + (rem > thr).
    - Then r = r + out_offset (wrap).
    - Clamp: r = max(r, act_min), then r = min(r, act_max). If act_min > act_max, the result is act_max.
- Config writes take effect for any REQUANT accepted after the config response completes.
- Reset in any state:
  - Aborts any in-flight op; the response is lost.
  - Returns all outputs and registers to their reset values on the next edge.

Optional Feature:
- Macro: CFUOP_REQUANT_PACK_EN.
- When defined, sub-op 3 is REQUANT_PACK:
  - Same datapath as REQUANT.
  - The low byte of the clamped result is written into byte lane pack_cnt of a 32-bit pack register.
  - pack_cnt is a 2-bit counter, reset 0, that increments per REQUANT_PACK and wraps 3->0.
  - The response returns the pack register after the write (lanes not yet written read 0 after wrap or reset).
  - The pack register is cleared when pack_cnt wraps to 0 on acceptance of the next lane-0 op.
- When not defined: no pack register or counter; sub-op 3 as in Behaviour.

Test Plan:
- Reset, then REQUANT acc=1000 bias=0 with default config -> cmd_ready=1 after reset; rsp_valid exactly 4 cycles after accept; output 0.
- SET_MULT(0x40000000, -1); SET_OUT(-200, min=-128 max=127); REQUANT acc=1000 bias=24 -> 56 (0xFFFFFF.. not involved; 1024 -> 512 -> 256 -> 56).
- Negative rounding: SET_MULT(0x40000000, -1); SET_OUT(0, -128, 127); REQUANT acc=-3 bias=0 -> 0xFFFFFFFF (-1).
- Saturation corner: SET_MULT(0x80000000, 0); SET_OUT(0, -32768, 32767); REQUANT acc=0x80000000 bias=0 -> 32767. With act_max=127 -> 127.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid=1, output stable, cmd_ready=0 throughout. rsp_ready=1 -> rsp_valid=0 and cmd_ready=1 next cycle.
- Reset asserted one cycle after a REQUANT accept -> no rsp_valid ever for that op; cmd_ready=1; a following REQUANT acc=5 with defaults returns 0. With CFUOP_REQUANT_PACK_EN defined, four REQUANT_PACK ops with results 1, 2, 3, 4 (mult=0x7FFFFFFF, shift 0) -> final response 0x04030201.
